dsp_block_proc: RTL and testbench

- Processing stage between two ping-pong RAM banks in the SPI data path.
- When source bank 0 is full (readyb0) and destination bank 1 is free (readya1), it sweeps read addresses 0..127 on RAM0 port B.
- Each returned byte is transformed and written to the same address in RAM1 port A.
- On completion it pulses finishb0/finisha1 so the ping-pong controller can swap banks.

---
 rtl/dsp_pkg.sv | 17 +
 rtl/dsp_datapath.sv | 44 ++++
 rtl/dsp_block_proc.sv | 88 ++++++++
 tb/tb_dsp_block_proc.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared constants and FSM state type for the SPI ping-pong processing stage.
package dsp_pkg;

    localparam int DEPTH  = 128;
    localparam int DW     = 8;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [DW-1:0] ADD_CONST = 8'd1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/dsp_datapath.sv
// Two-stage pipeline aligning the RAM0 read latency with the RAM1 write:
// stage 1 tracks valid/address, stage 2 adds ADD_CONST and drives the write port.
module dsp_datapath
    import dsp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DW-1:0]     datain,
    output logic [DW-1:0]     dataout,
    output logic [ADDR_W-1:0] addra1,
    output logic              wea1
);

    logic              v1;
    logic [ADDR_W-1:0] a1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            a1 <= '0;
        end else begin
            v1 <= rd_valid;
            a1 <= rd_addr;
        end
    end

    // Data and address only move on a valid write so RAM1 sees stable values otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wea1    <= 1'b0;
            addra1  <= '0;
            dataout <= '0;
        end else begin
            wea1 <= v1;
            if (v1) begin
                addra1  <= a1;
                dataout <= datain + ADD_CONST;
            end
        end
    end

endmodule

// File: rtl/dsp_block_proc.sv
// Block processor between ping-pong RAM banks: sweeps RAM0, writes transformed
// samples to RAM1 and pulses finish flags when the whole block has been written.
module dsp_block_proc
    import dsp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DW-1:0]     datain,
    output logic [DW-1:0]     dataout,
    input  logic              readyb0,
    input  logic              readya1,
    output logic [ADDR_W-1:0] addrb0,
    output logic [ADDR_W-1:0] addra1,
    output logic              finishb0,
    output logic              finisha1,
    output logic              wea1
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_next;
    logic              rd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            addrb0 <= '0;
        end else begin
            state  <= state_next;
            addrb0 <= addr_next;
        end
    end

    // Address 0 is already on the bus in IDLE, so the start cycle counts as its read.
    always_comb begin
        state_next = state;
        addr_next  = addrb0;
        rd_valid   = 1'b0;
        finishb0   = 1'b0;
        finisha1   = 1'b0;
        case (state)
            IDLE: begin
                addr_next = '0;
                if (readyb0 && readya1) begin
                    state_next = RUN;
                    addr_next  = ADDR_W'(1);
                    rd_valid   = 1'b1;
                end
            end
            RUN: begin
                rd_valid = 1'b1;
                if (addrb0 == LAST_ADDR) begin
                    state_next = DRAIN;
                end else begin
                    addr_next = addrb0 + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (wea1 && (addra1 == LAST_ADDR)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                finishb0   = 1'b1;
                finisha1   = 1'b1;
                addr_next  = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    dsp_datapath u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_valid (rd_valid),
        .rd_addr  (addrb0),
        .datain   (datain),
        .dataout  (dataout),
        .addra1   (addra1),
        .wea1     (wea1)
    );

endmodule

// File: tb/tb_dsp_block_proc.sv
// Directed bench for dsp_block_proc with RAM0/RAM1 behavioural models.
module tb_dsp_block_proc;

    logic       clk;
    logic       rst_n;
    logic [7:0] datain;
    logic [7:0] dataout;
    logic       readyb0;
    logic       readya1;
    logic [6:0] addrb0;
    logic [6:0] addra1;
    logic       finishb0;
    logic       finisha1;
    logic       wea1;

    logic [7:0] mem0 [128];
    logic [7:0] mem1 [128];
    logic [7:0] ram_data;
    logic [7:0] free_data;
    logic       free_mode;

    int vector_count;
    int miscompare_count;

    dsp_block_proc dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .datain   (datain),
        .dataout  (dataout),
        .readyb0  (readyb0),
        .readya1  (readya1),
        .addrb0   (addrb0),
        .addra1   (addra1),
        .finishb0 (finishb0),
        .finisha1 (finisha1),
        .wea1     (wea1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM0, write-only RAM1, and a free-running sample source.
    always @(posedge clk) begin
        ram_data <= mem0[addrb0];
        if (wea1) mem1[addra1] <= dataout;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) free_data <= 8'h0F;
        else        free_data <= free_data + 8'd1;
    end

    assign datain = free_mode ? free_data : ram_data;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rb0, input logic ra1);
        readyb0 = rb0;
        readya1 = ra1;
    endtask

    initial begin
        int         exp_addr;
        int         pulses;
        int         pulse_at [4];
        int         wr_idx;
        logic [7:0] prev_din;
        logic       saw_finish;
        logic [7:0] exp_mem;

        vector_count     = 0;
        miscompare_count = 0;
        free_mode        = 1'b0;
        ram_data         = 8'h00;
        applyStimulus(1'b0, 1'b0);
        for (int k = 0; k < 128; k++) begin
            mem0[k] = (k == 127) ? 8'hFF : 8'(k + 15);
            mem1[k] = 8'hAA;
        end

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_addrb0", 32'(addrb0), 0);
        checkOutput("reset_addra1", 32'(addra1), 0);
        checkOutput("reset_dataout", 32'(dataout), 0);
        checkOutput("reset_wea1", 32'(wea1), 0);
        checkOutput("reset_finishb0", 32'(finishb0), 0);
        checkOutput("reset_finisha1", 32'(finisha1), 0);
        rst_n = 1'b1;

        $display("[TB] gating: readya1 low holds the block off");
        applyStimulus(1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("gate_addrb0", 32'(addrb0), 0);
            checkOutput("gate_wea1", 32'(wea1), 0);
            checkOutput("gate_finish", 32'(finishb0), 0);
        end

        $display("[TB] single block with RAM model");
        @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        #1;
        for (int j = 0; j < 136; j++) begin
            if (j > 0) @(negedge clk);
            exp_addr = (j >= 131) ? 0 : ((j > 127) ? 127 : j);
            checkOutput("blk_addrb0", 32'(addrb0), 32'(exp_addr));
            checkOutput("blk_wea1", 32'(wea1), 32'(j >= 2 && j <= 129));
            checkOutput("blk_finishb0", 32'(finishb0), 32'(j == 130));
            checkOutput("blk_finisha1", 32'(finisha1), 32'(j == 130));
            if (j >= 2 && j <= 129) begin
                checkOutput("blk_addra1", 32'(addra1), 32'(j - 2));
                checkOutput("blk_dataout", 32'(dataout), 32'(8'(mem0[j - 2] + 8'd1)));
            end
            if (j == 5) applyStimulus(1'b0, 1'b0);
        end
        for (int k = 0; k < 128; k++) begin
            exp_mem = (k == 127) ? 8'h00 : 8'(k + 16);
            checkOutput("ram1_content", 32'(mem1[k]), 32'(exp_mem));
        end

        $display("[TB] asynchronous reset mid-block");
        applyStimulus(1'b1, 1'b1);
        repeat (40) @(negedge clk);
        checkOutput("pre_reset_wea1", 32'(wea1), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_addrb0", 32'(addrb0), 0);
        checkOutput("abort_addra1", 32'(addra1), 0);
        checkOutput("abort_dataout", 32'(dataout), 0);
        checkOutput("abort_wea1", 32'(wea1), 0);
        checkOutput("abort_finishb0", 32'(finishb0), 0);
        checkOutput("abort_finisha1", 32'(finisha1), 0);
        applyStimulus(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_finish = 1'b0;
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            if (finishb0 || finisha1 || wea1) saw_finish = 1'b1;
        end
        checkOutput("abort_no_finish", 32'(saw_finish), 0);

        $display("[TB] free-running datain, back-to-back blocks");
        rst_n     = 1'b0;
        free_mode = 1'b1;
        applyStimulus(1'b1, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        pulses   = 0;
        wr_idx   = 0;
        prev_din = datain;
        for (int j = 0; j < 450; j++) begin
            if (j > 0) @(negedge clk);
            if (wea1) begin
                checkOutput("free_dataout", 32'(dataout), 32'(8'(prev_din + 8'd1)));
                checkOutput("free_addra1", 32'(addra1), 32'(wr_idx % 128));
                wr_idx++;
            end
            if (finishb0) begin
                checkOutput("free_finisha1", 32'(finisha1), 1);
                if (pulses < 4) pulse_at[pulses] = j;
                pulses++;
            end
            prev_din = datain;
        end
        checkOutput("free_pulse_count", 32'(pulses), 3);
        checkOutput("free_write_count", 32'(wr_idx), 439);
        if (pulses >= 3) begin
            checkOutput("free_first_pulse", 32'(pulse_at[0]), 130);
            checkOutput("free_period_1", 32'(pulse_at[1] - pulse_at[0]), 131);
            checkOutput("free_period_2", 32'(pulse_at[2] - pulse_at[1]), 131);
        end

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
